// File: rtl/cdc_2phase_rx_fifo_if.sv
// Handshake bundle for the two-phase CDC receiver: async req/ack/data from the
// source domain plus the destination-side valid/ready stream, flush and fill level.
interface cdc_2phase_rx_fifo_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    logic                         async_req_i;
    logic [DW-1:0]                async_data_i;
    logic                         async_ack_o;
    logic [DW-1:0]                data_o;
    logic                         valid_o;
    logic                         ready_i;
    logic                         flush_i;
    logic [$clog2(DEPTH+1)-1:0]   count_o;

    // slave: the receiver itself; master: whoever drives the source and consumer sides
    modport slave (
        input  async_req_i, async_data_i, ready_i, flush_i,
        output async_ack_o, data_o, valid_o, count_o
    );

    modport master (
        output async_req_i, async_data_i, ready_i, flush_i,
        input  async_ack_o, data_o, valid_o, count_o
    );
endinterface

// File: rtl/cdc_2phase_rx_fifo.sv
// Destination end of a toggle req/ack crossing with a DEPTH-entry FWFT buffer.
// Items are acked on capture, so the source streams while the consumer stalls.
module cdc_2phase_rx_fifo #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cdc_2phase_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [SYNC_STAGES-1:0]       sync_q;
    logic                         req_s;
    logic                         ack_q, ack_d;
    logic [AW-1:0]                wptr_q, wptr_d;
    logic [AW-1:0]                rptr_q, rptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0][DW-1:0]     mem_q;

    logic pending, full, not_empty, push, pop;

    // Plain shift chain; nothing combinational between stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.async_req_i};
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign pending   = req_s ^ ack_q;
    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    // Both decisions use the registered count: a same-cycle pop never frees room.
    assign push      = pending && !full && !bus.flush_i;
    assign pop       = not_empty && bus.ready_i && !bus.flush_i;

    always_comb begin
        ack_d   = ack_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            ack_d  = ~ack_q;
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        if (bus.flush_i) begin
            // ack_q is left alone so parity with the source survives a flush.
            rptr_d  = wptr_q;
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            ack_q   <= ack_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= bus.async_data_i;
        end
    end

    assign bus.async_ack_o = ack_q;
    assign bus.data_o      = mem_q[rptr_q];
    assign bus.valid_o     = not_empty;
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_cdc_2phase_rx_fifo.sv
// Directed bench for cdc_2phase_rx_fifo: two instances (2- and 3-stage synchroniser),
// inputs driven and outputs sampled on the falling clock edge.
module tb_cdc_2phase_rx_fifo;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   tx, rx;

    cdc_2phase_rx_fifo_if #(.DW(32), .DEPTH(4)) ifa ();
    cdc_2phase_rx_fifo_if #(.DW(32), .DEPTH(4)) ifb ();

    cdc_2phase_rx_fifo #(.DW(32), .DEPTH(4), .SYNC_STAGES(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa)
    );

    cdc_2phase_rx_fifo #(.DW(32), .DEPTH(4), .SYNC_STAGES(3)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        ifa.async_data_i = d;
        ifa.async_req_i  = !ifa.async_req_i;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (ifa.async_ack_o !== ifa.async_req_i && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});
    endtask

    initial begin
        rst = 1'b1;
        ifa.async_req_i = 0; ifa.async_data_i = '0; ifa.ready_i = 0; ifa.flush_i = 0;
        ifb.async_req_i = 0; ifb.async_data_i = '0; ifb.ready_i = 0; ifb.flush_i = 0;

        // reset state
        tick(1);
        chk("rst_ack",   {31'b0, ifa.async_ack_o}, 0);
        chk("rst_valid", {31'b0, ifa.valid_o}, 0);
        chk("rst_count", {29'b0, ifa.count_o}, 0);
        chk("rst_data",  ifa.data_o, 0);
        chk("rst_b_valid", {31'b0, ifb.valid_o}, 0);
        rst = 1'b0;
        tick(1);

        // single item, 3-cycle latency
        send(32'hDEAD_BEEF);
        tick(2);
        chk("one_early_valid", {31'b0, ifa.valid_o}, 0);
        chk("one_early_ack",   {31'b0, ifa.async_ack_o}, 0);
        tick(1);
        chk("one_ack",   {31'b0, ifa.async_ack_o}, 1);
        chk("one_valid", {31'b0, ifa.valid_o}, 1);
        chk("one_data",  ifa.data_o, 32'hDEAD_BEEF);
        chk("one_count", {29'b0, ifa.count_o}, 1);
        ifa.ready_i = 1;
        tick(1);
        ifa.ready_i = 0;
        chk("one_pop_valid", {31'b0, ifa.valid_o}, 0);
        chk("one_pop_count", {29'b0, ifa.count_o}, 0);

        // fill to DEPTH, fifth item stalls
        for (int i = 1; i <= 4; i++) begin
            send(i);
            wait_ack("fill_ack", 6);
        end
        chk("fill_count", {29'b0, ifa.count_o}, 4);
        send(5);
        tick(6);
        chk("stall_ack",   {31'b0, ifa.async_ack_o}, {31'b0, !ifa.async_req_i});
        chk("stall_count", {29'b0, ifa.count_o}, 4);
        chk("stall_head",  ifa.data_o, 1);
        ifa.ready_i = 1;
        tick(1);
        ifa.ready_i = 0;
        chk("stall_pop_count", {29'b0, ifa.count_o}, 3);
        chk("stall_pop_ack",   {31'b0, ifa.async_ack_o}, {31'b0, !ifa.async_req_i});
        tick(1);
        chk("stall_cap_ack",   {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});
        chk("stall_cap_count", {29'b0, ifa.count_o}, 4);
        ifa.ready_i = 1;
        for (int i = 2; i <= 5; i++) begin
            chk("fill_order", ifa.data_o, i);
            tick(1);
        end
        ifa.ready_i = 0;
        chk("fill_drained", {29'b0, ifa.count_o}, 0);

        // simultaneous push and pop at count=2
        send(32'hA1); wait_ack("sim_ack", 6);
        send(32'hA2); wait_ack("sim_ack", 6);
        send(32'hA3);
        tick(2);
        ifa.ready_i = 1;
        tick(1);
        ifa.ready_i = 0;
        chk("sim2_count", {29'b0, ifa.count_o}, 2);
        chk("sim2_head",  ifa.data_o, 32'hA2);
        chk("sim2_ack",   {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});

        // pop with a pending item while full: capture follows a cycle later
        send(32'hA4); wait_ack("sim_ack", 6);
        send(32'hA5); wait_ack("sim_ack", 6);
        chk("sim4_full", {29'b0, ifa.count_o}, 4);
        send(32'hA6);
        tick(3);
        chk("sim4_stall_ack", {31'b0, ifa.async_ack_o}, {31'b0, !ifa.async_req_i});
        ifa.ready_i = 1;
        tick(1);
        ifa.ready_i = 0;
        chk("sim4_count", {29'b0, ifa.count_o}, 3);
        chk("sim4_head",  ifa.data_o, 32'hA3);
        chk("sim4_noack", {31'b0, ifa.async_ack_o}, {31'b0, !ifa.async_req_i});
        tick(1);
        chk("sim4_cap_count", {29'b0, ifa.count_o}, 4);
        chk("sim4_cap_ack",   {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});
        ifa.ready_i = 1;
        for (int i = 3; i <= 6; i++) begin
            chk("sim4_order", ifa.data_o, 32'hA0 + i);
            tick(1);
        end
        ifa.ready_i = 0;
        chk("sim4_drained", {29'b0, ifa.count_o}, 0);

        // wrap-around streaming with ready toggling
        tx = 0; rx = 0;
        for (int c = 0; c < 300 && rx < 10; c++) begin
            ifa.ready_i = c[0];
            if (ifa.valid_o && ifa.ready_i) begin
                chk("wrap_data", ifa.data_o, 32'h10 + rx);
                rx++;
            end
            if (ifa.async_ack_o == ifa.async_req_i && tx < 10) begin
                send(32'h10 + tx);
                tx++;
            end
            chk("wrap_cnt", {31'b0, ifa.count_o <= 3'd4}, 1);
            tick(1);
        end
        ifa.ready_i = 0;
        chk("wrap_rx",    rx, 10);
        chk("wrap_empty", {29'b0, ifa.count_o}, 0);

        // flush with three buffered and one pending
        send(32'hB1); wait_ack("fl_ack", 6);
        send(32'hB2); wait_ack("fl_ack", 6);
        send(32'hB3); wait_ack("fl_ack", 6);
        send(32'hB4);
        tick(2);
        ifa.flush_i = 1;
        tick(1);
        ifa.flush_i = 0;
        chk("fl_count",   {29'b0, ifa.count_o}, 0);
        chk("fl_valid",   {31'b0, ifa.valid_o}, 0);
        chk("fl_held_ack",{31'b0, ifa.async_ack_o}, {31'b0, !ifa.async_req_i});
        tick(1);
        chk("fl_cap_count", {29'b0, ifa.count_o}, 1);
        chk("fl_cap_ack",   {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});
        chk("fl_cap_data",  ifa.data_o, 32'hB4);
        tick(3);
        chk("fl_once_ack",   {31'b0, ifa.async_ack_o}, {31'b0, ifa.async_req_i});
        chk("fl_once_count", {29'b0, ifa.count_o}, 1);
        ifa.ready_i = 1;
        tick(1);
        ifa.ready_i = 0;
        chk("fl_drained", {29'b0, ifa.count_o}, 0);

        // async reset between edges with two entries buffered
        send(32'hC1); wait_ack("ar_ack", 6);
        send(32'hC2); wait_ack("ar_ack", 6);
        chk("ar_pre_count", {29'b0, ifa.count_o}, 2);
        #2;
        rst = 1'b1;
        ifa.async_req_i = 0;
        #1;
        chk("ar_ack",   {31'b0, ifa.async_ack_o}, 0);
        chk("ar_valid", {31'b0, ifa.valid_o}, 0);
        chk("ar_count", {29'b0, ifa.count_o}, 0);
        chk("ar_data",  ifa.data_o, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        send(32'hC3);
        tick(2);
        chk("ar_early_valid", {31'b0, ifa.valid_o}, 0);
        tick(1);
        chk("ar_cap_valid", {31'b0, ifa.valid_o}, 1);
        chk("ar_cap_ack",   {31'b0, ifa.async_ack_o}, 1);
        chk("ar_cap_data",  ifa.data_o, 32'hC3);
        chk("ar_cap_count", {29'b0, ifa.count_o}, 1);

        // three-stage synchroniser: 4-cycle latency
        ifb.async_data_i = 32'h5A5A_5A5A;
        ifb.async_req_i  = 1;
        tick(3);
        chk("s3_early_valid", {31'b0, ifb.valid_o}, 0);
        chk("s3_early_ack",   {31'b0, ifb.async_ack_o}, 0);
        tick(1);
        chk("s3_valid", {31'b0, ifb.valid_o}, 1);
        chk("s3_ack",   {31'b0, ifb.async_ack_o}, 1);
        chk("s3_data",  ifb.data_o, 32'h5A5A_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdc_2phase_rx_fifo.md
Name: cdc_2phase_rx_fifo

Overview:
Destination-side receiver for the two-phase (toggle req/ack) clock-domain-crossing protocol, clocked only in the destination domain. Adds a configurable synchroniser depth and a DEPTH-entry buffer. Each item is acknowledged as soon as it is captured into the buffer, not when the consumer accepts it, so the source can stream items back-to-back while the consumer stalls. Sits at the destination end of the debug-module/JTAG crossing in place of a bare single-entry receiver.

Parameters:
DW, 32, payload width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
SYNC_STAGES, 2, flops in the async_req_i synchroniser chain (>=2)

Ports:
clk_i  input  1  destination clock; all state on posedge
rst_i  input  1  asynchronous reset, active-high
async_req_i  input  1  request toggle from the source domain; asynchronous
async_data_i  input  DW  payload from the source domain; held stable by the source from its req toggle until the matching ack toggle
async_ack_o  output  1  ack toggle returned to the source domain; driven directly from a flop
data_o  output  DW  payload at the head of the buffer
valid_o  output  1  buffer not empty
ready_i  input  1  consumer accepts the head entry
flush_i  input  1  synchronous discard of all buffered entries
count_o  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (rst_i=1, takes effect immediately, no clock needed): synchroniser flops=0, ack flop=0, read and write pointers=0, count=0, storage=0. Outputs during and after reset: async_ack_o=0, valid_o=0, data_o=0, count_o=0.
- Synchroniser: a shift chain of SYNC_STAGES flops samples async_req_i. req_s is the last stage. No logic sits between the chain stages.
- Pending item: req_s != ack_q.
- Capture condition: pending && count<DEPTH && !flush_i.
- On capture: storage[wptr] <= async_data_i; wptr increments, wrapping modulo DEPTH; ack_q toggles.
- Capture is evaluated against the registered count. A pop in the same cycle does not allow a push into a full buffer.
- Latency: the first posedge that samples the new async_req_i level is edge 1. req_s changes after edge SYNC_STAGES. Capture and the ack toggle happen at edge SYNC_STAGES+1. valid_o rises after that edge (3 cycles for the default).
- At most one capture per cycle. A second item cannot be pending until the source sees the ack, so no items are lost.
- Pop: when valid_o && ready_i && !flush_i, rptr increments, wrapping modulo DEPTH.
- First-word fall-through: data_o = storage[rptr], read combinationally from flops. data_o is undefined-but-stable when valid_o=0; the implementation drives the stale entry.
- Count: +1 on capture only, -1 on pop only, unchanged on both or neither. valid_o = (count!=0).
- Full (count==DEPTH): capture stalls. ack_q is held, so the source's ready stays low, which is the backpressure. Capture proceeds on the first cycle after count drops below DEPTH.
- Flush: flush_i=1 sets rptr<=wptr and count<=0, and suppresses both pop and capture that cycle. A pending item is captured on the next cycle with flush_i=0. ack_q is never altered by flush, so req/ack parity with the source is preserved.
- ready_i while empty: no effect.
- Wrap-around: pointers are $clog2(DEPTH) bits; fullness and emptiness come only from count.

Test Plan:
- Reset then single item: toggle async_req_i 0->1 with async_data_i=32'hDEAD_BEEF, ready_i=0 -> async_ack_o toggles to 1 and valid_o=1 three cycles later, data_o=DEAD_BEEF, count_o=1; assert ready_i one cycle -> valid_o=0, count_o=0.
- Fill and stall: with DEPTH=4 and ready_i=0, send items 1..5 -> count_o reaches 4 and async_ack_o toggles exactly 4 times; item 5 is held with no toggle. Pop once -> item 5 is captured the next cycle and async_ack_o toggles; pop order is 1,2,3,4,5.
- Simultaneous push/pop at count=2: pending capture with ready_i=1 -> count_o stays 2, head advances. At count=4 with pop and pending item -> count_o becomes 3, and the capture follows one cycle later.
- Wrap-around: stream 10 items (values 0x10..0x19) with ready_i toggling every other cycle -> all 10 are received in order and count_o never exceeds 4.
- Flush: 3 items buffered plus 1 pending, assert flush_i for one cycle -> count_o=0 and valid_o=0 after the edge. The pending item is captured the next cycle, count_o=1, and the ack toggles exactly once for it.
- Async reset mid-stream: assert rst_i between clock edges with count_o=2 -> async_ack_o, valid_o, count_o and data_o go to 0 immediately, and the first item after release is captured normally. Repeat with SYNC_STAGES=3 -> latency is 4 cycles.
